// File: rtl/audio_stream_pkg.sv
// Shared constants and types for the audio stream packetizer.
package audio_stream_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, SYNC, DATA} pkt_state_t;

  // Wrap point of the decimation counter; 0 and 1 both mean "every sample".
  function automatic logic [7:0] decim_limit(input logic [7:0] decim);
    return (decim <= 8'd1) ? 8'd0 : decim - 8'd1;
  endfunction

endpackage

// File: rtl/audio_stream_packetizer_decimator.sv
// Sample-strobe decimator: flags every decim_in-th accepted sample set as a capture.
module stream_decimator
  import audio_stream_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic [7:0] decim_in,
  input  logic       valid_in,
  output logic       capture_out
);

  logic [7:0] cnt;

  // Counter wraps with >= so a shrinking decim_in never strands it above the limit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= 8'd0;
    end else if (!enable_in) begin
      cnt <= 8'd0;
    end else if (valid_in) begin
      cnt <= (cnt >= decim_limit(decim_in)) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign capture_out = enable_in && valid_in && (cnt == 8'd0);

endmodule

// File: rtl/audio_stream_packetizer.sv
// Multi-channel sample packetizer: decimates, truncates and serialises frames onto a
// valid/ready byte stream with one frame of buffering and a saturating drop counter.
module audio_stream_packetizer
  import audio_stream_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned OUT_BYTES = 2,
  parameter bit          SYNC_EN   = 1'b1
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               enable_in,
  input  logic [7:0]                         decim_in,
  input  logic [$clog2(NUM_CH+1)-1:0]        num_ch_in,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]    sample_in,
  input  logic                               valid_in,
  output logic [7:0]                         tx_data_out,
  output logic                               tx_valid_out,
  input  logic                               tx_ready_in,
  output logic                               busy_out,
  output logic                               frame_done_out,
  output logic [15:0]                        drop_count_out
);

  localparam int unsigned CH_W    = $clog2(NUM_CH + 1);
  localparam int unsigned OUT_W   = OUT_BYTES * 8;
  localparam int unsigned FRAME_W = NUM_CH * OUT_W;
  localparam int unsigned BI_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  pkt_state_t          state;
  logic                capture;
  logic [FRAME_W-1:0]  cap_frame, act_frame, pend_frame, start_frame;
  logic [CH_W-1:0]     cap_nch, act_nch, pend_nch, start_nch;
  logic [BI_W-1:0]     byte_idx;
  logic [CH_W-1:0]     ch_idx;
  logic                pend_valid, pend_valid_nxt;
  logic                hs, last_hs, pend_ok, start, drop_inc, busy_nxt;
  logic                unused_sample_bits;

  stream_decimator u_decim (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .enable_in   (enable_in),
    .decim_in    (decim_in),
    .valid_in    (valid_in),
    .capture_out (capture)
  );

  // Truncated capture image, ch0 in the most significant slot so bytes shift out MSB first.
  always_comb begin
    cap_frame = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cap_frame[(NUM_CH-1-i)*OUT_W +: OUT_W] = sample_in[i][SAMPLE_W-1 -: OUT_W];
    end
    if (num_ch_in == '0)                     cap_nch = CH_W'(1);
    else if (num_ch_in > CH_W'(NUM_CH))      cap_nch = CH_W'(NUM_CH);
    else                                     cap_nch = num_ch_in;
  end

  assign unused_sample_bits = ^sample_in;

  // Handshake decode and next-frame selection; pending always outranks a fresh capture.
  always_comb begin
    hs       = tx_valid_out && tx_ready_in;
    last_hs  = (state == DATA) && hs && (byte_idx == BI_W'(OUT_BYTES - 1)) &&
               (ch_idx == act_nch - CH_W'(1));
    pend_ok  = pend_valid && enable_in;
    start    = ((state == IDLE) && capture) || (last_hs && (pend_ok || capture));
    start_frame = (last_hs && pend_ok) ? pend_frame : cap_frame;
    start_nch   = (last_hs && pend_ok) ? pend_nch   : cap_nch;
    drop_inc = capture && (state != IDLE) && !last_hs && pend_valid;

    if (last_hs && pend_ok)                             pend_valid_nxt = capture;
    else if (!enable_in)                                pend_valid_nxt = 1'b0;
    else if (capture && (state != IDLE) && !last_hs)    pend_valid_nxt = 1'b1;
    else                                                pend_valid_nxt = pend_valid;

    busy_nxt = start || ((state != IDLE) && !last_hs) || pend_valid_nxt;
  end

  // Serializer FSM with active/pending frame registers and drop counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      act_frame      <= '0;
      act_nch        <= '0;
      pend_frame     <= '0;
      pend_nch       <= '0;
      pend_valid     <= 1'b0;
      byte_idx       <= '0;
      ch_idx         <= '0;
      tx_data_out    <= 8'h00;
      tx_valid_out   <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      drop_count_out <= 16'h0000;
    end else begin
      frame_done_out <= last_hs;
      busy_out       <= busy_nxt;
      pend_valid     <= pend_valid_nxt;

      if (start) begin
        act_nch      <= start_nch;
        byte_idx     <= '0;
        ch_idx       <= '0;
        tx_valid_out <= 1'b1;
        if (SYNC_EN) begin
          state       <= SYNC;
          tx_data_out <= SYNC_BYTE;
          act_frame   <= start_frame;
        end else begin
          state       <= DATA;
          tx_data_out <= start_frame[FRAME_W-1 -: 8];
          act_frame   <= start_frame << 8;
        end
      end else if (last_hs) begin
        state        <= IDLE;
        tx_valid_out <= 1'b0;
        tx_data_out  <= 8'h00;
      end else if (hs) begin
        state       <= DATA;
        tx_data_out <= act_frame[FRAME_W-1 -: 8];
        act_frame   <= act_frame << 8;
        if (state == DATA) begin
          if (byte_idx == BI_W'(OUT_BYTES - 1)) begin
            byte_idx <= '0;
            ch_idx   <= ch_idx + CH_W'(1);
          end else begin
            byte_idx <= byte_idx + BI_W'(1);
          end
        end
      end

      // Pending slot takes a capture only while a frame is in flight.
      if (last_hs && pend_ok) begin
        if (capture) begin
          pend_frame <= cap_frame;
          pend_nch   <= cap_nch;
        end
      end else if (enable_in && capture && (state != IDLE) && !last_hs && !pend_valid) begin
        pend_frame <= cap_frame;
        pend_nch   <= cap_nch;
      end

      if (drop_inc && (drop_count_out != 16'hFFFF)) begin
        drop_count_out <= drop_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_packetizer.sv
// Scoreboard bench for audio_stream_packetizer (NUM_CH=4, SAMPLE_W=24, OUT_BYTES=2, SYNC_EN=1).
module tb_audio_stream_packetizer;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SAMPLE_W = 24;

  logic                              clk_in = 1'b0;
  logic                              rst_in;
  logic                              enable_in;
  logic [7:0]                        decim_in;
  logic [2:0]                        num_ch_in;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   sample_in;
  logic                              valid_in;
  logic [7:0]                        tx_data_out;
  logic                              tx_valid_out;
  logic                              tx_ready_in;
  logic                              busy_out;
  logic                              frame_done_out;
  logic [15:0]                       drop_count_out;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_byte_t;

  exp_byte_t exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  bit        done_pend = 1'b0;

  audio_stream_packetizer #(
    .NUM_CH(4), .SAMPLE_W(24), .OUT_BYTES(2), .SYNC_EN(1'b1)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .decim_in       (decim_in),
    .num_ch_in      (num_ch_in),
    .sample_in      (sample_in),
    .valid_in       (valid_in),
    .tx_data_out    (tx_data_out),
    .tx_valid_out   (tx_valid_out),
    .tx_ready_in    (tx_ready_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected byte sequence for one frame: sync byte then top 16 bits of each channel.
  task automatic push_frame(input logic [NUM_CH-1:0][SAMPLE_W-1:0] s, input int nch);
    exp_byte_t e;
    e.data = 8'hA5;
    e.last = 1'b0;
    exp_q.push_back(e);
    for (int c = 0; c < nch; c++) begin
      for (int b = 0; b < 2; b++) begin
        e.data = s[c][23-8*b -: 8];
        e.last = (c == nch - 1) && (b == 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [NUM_CH-1:0][SAMPLE_W-1:0] s, input logic [2:0] n);
    @(posedge clk_in); #1;
    sample_in = s;
    num_ch_in = n;
    valid_in  = 1'b1;
    @(posedge clk_in); #1;
    valid_in  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !busy_out) break;
      @(posedge clk_in); #1;
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_busy", busy_out, 1'b0);
  endtask

  // Byte monitor: pops the scoreboard on each handshake, checks frame_done one cycle later.
  always @(negedge clk_in) begin
    if (rst_in) begin
      done_pend = 1'b0;
    end else begin
      if (done_pend || frame_done_out) check_eq("frame_done", frame_done_out, done_pend);
      done_pend = 1'b0;
      if (tx_valid_out && tx_ready_in) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte_q", exp_q.size(), 1);
        end else begin
          exp_byte_t e;
          e = exp_q.pop_front();
          check_eq("tx_byte", tx_data_out, e.data);
          done_pend = e.last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0][SAMPLE_W-1:0] s, s2, s3, s4;
    int cyc;

    rst_in = 1'b1; enable_in = 1'b1; decim_in = 8'd1; num_ch_in = 3'd2;
    sample_in = '0; valid_in = 1'b0; tx_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_tx_valid", tx_valid_out, 1'b0);
    check_eq("rst_tx_data", tx_data_out, 8'h00);
    check_eq("rst_busy", busy_out, 1'b0);
    check_eq("rst_frame_done", frame_done_out, 1'b0);
    check_eq("rst_drop", drop_count_out, 16'h0);
    rst_in = 1'b0;

    // Basic 2-channel frame.
    s = '0; s[0] = 24'h123456; s[1] = 24'hABCDEF;
    push_frame(s, 2);
    send(s, 3'd2);
    check_eq("first_byte_latency", tx_valid_out, 1'b1);
    wait_drain(40);

    // Back-pressure on the second byte.
    push_frame(s, 2);
    send(s, 3'd2);
    @(posedge clk_in); #1;
    tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_data", tx_data_out, 8'h12);
      check_eq("hold_valid", tx_valid_out, 1'b1);
      @(posedge clk_in); #1;
    end
    tx_ready_in = 1'b1;
    wait_drain(40);

    // Three captures while stalled: oldest two kept, third dropped.
    s = '0;  s[0]  = 24'h111111; s[1]  = 24'h222222;
    s2 = '0; s2[0] = 24'h333333; s2[1] = 24'h444444;
    s3 = '0; s3[0] = 24'h555555; s3[1] = 24'h666666;
    tx_ready_in = 1'b0;
    push_frame(s, 2);
    push_frame(s2, 2);
    send(s, 3'd2);
    send(s2, 3'd2);
    send(s3, 3'd2);
    check_eq("drop_one", drop_count_out, 16'd1);
    check_eq("busy_stalled", busy_out, 1'b1);
    tx_ready_in = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    check_eq("back_to_back_cycles", cyc, 10);
    wait_drain(20);

    // Decimation by 3 over a ramp.
    decim_in = 8'd3;
    for (int i = 0; i < 9; i++) begin
      s = '0;
      s[0] = {8'(i), 16'h55AA};
      s[1] = {8'(8'h80 + i), 16'h33CC};
      if (i % 3 == 0) push_frame(s, 2);
      send(s, 3'd2);
      repeat (7) @(posedge clk_in);
      #1;
    end
    wait_drain(40);
    decim_in = 8'd1;

    // Reset in the middle of a frame.
    s = '0; s[0] = 24'h123456; s[1] = 24'hABCDEF;
    push_frame(s, 2);
    send(s, 3'd2);
    @(posedge clk_in);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    exp_q.delete();
    check_eq("midrst_tx_valid", tx_valid_out, 1'b0);
    check_eq("midrst_busy", busy_out, 1'b0);
    check_eq("midrst_drop", drop_count_out, 16'h0);
    push_frame(s, 2);
    send(s, 3'd2);
    check_eq("restart_sync", tx_data_out, 8'hA5);
    wait_drain(40);

    // Channel count clamping.
    push_frame(s, 1);
    send(s, 3'd0);
    wait_drain(40);
    s4 = '0;
    s4[0] = 24'h010203; s4[1] = 24'h111213; s4[2] = 24'h212223; s4[3] = 24'h313233;
    push_frame(s4, 4);
    send(s4, 3'd7);
    wait_drain(60);

    // Capture on the last handshake with pending full is not a drop.
    s = '0;  s[0]  = 24'h7A7B7C; s[1]  = 24'h6A6B6C;
    s2 = '0; s2[0] = 24'h5A5B5C; s2[1] = 24'h4A4B4C;
    s3 = '0; s3[0] = 24'h3A3B3C; s3[1] = 24'h2A2B2C;
    tx_ready_in = 1'b0;
    push_frame(s, 2);
    push_frame(s2, 2);
    send(s, 3'd2);
    send(s2, 3'd2);
    tx_ready_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    check_eq("last_byte_staged", tx_data_out, 8'h6B);
    push_frame(s3, 2);
    sample_in = s3; num_ch_in = 3'd2; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    check_eq("coincide_no_drop", drop_count_out, 16'h0);
    check_eq("coincide_busy", busy_out, 1'b1);
    wait_drain(60);
    check_eq("final_drop", drop_count_out, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
